// File: rtl/cal_pkg.sv
// Shared calendar constants, FSM state type and the month-length helper.
package cal_pkg;

  localparam int unsigned DATE_W   = 5;
  localparam int unsigned MONTH_W  = 4;
  localparam int unsigned LEAP_W   = 2;
  localparam int unsigned MONTHS   = 12;
  localparam int unsigned FEB      = 2;
  localparam int unsigned DEC      = 12;
  localparam int unsigned MAX_DATE = 31;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } cal_state_t;

  // Number of days in a month; leap selects the 29-day February.
  function automatic logic [DATE_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                      input logic                leap);
    logic [DATE_W-1:0] days;
    days = DATE_W'(MAX_DATE);
    case (month)
      MONTH_W'(FEB):                          days = leap ? DATE_W'(29) : DATE_W'(28);
      MONTH_W'(4), MONTH_W'(6),
      MONTH_W'(9), MONTH_W'(11):              days = DATE_W'(30);
      default:                                days = DATE_W'(MAX_DATE);
    endcase
    return days;
  endfunction

endpackage

// File: rtl/cal_month_len.sv
// Combinational month-length lookup.
//   month : month number 1..12
//   leap  : 1 = current year is a leap year (February has 29 days)
//   last  : last valid date of that month
module cal_month_len
  import cal_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic               leap,
  output logic [DATE_W-1:0]  last
);

  assign last = days_in_month(month, leap);

endmodule

// File: rtl/cal_ctrl.sv
// Calendar sequencer: owns date, month and leap phase; advances on the
// day-rollover carry in run mode and on the Dateadv/Monthadv buttons in set mode.
//   clk        : system clock (1 pulse/sec)
//   rst        : asynchronous active-low reset
//   day_tick   : one-cycle carry from the hh:mm:ss chain
//   timeset    : 1 = set mode, 0 = run mode
//   dateadv    : set-mode date advance (level, one step per clk)
//   monthadv   : set-mode month advance (level, one step per clk)
//   date_out   : current date 1..31, zero-extended to W
//   month_out  : current month 1..12, zero-extended to W
//   leap_phase : years since last leap year (0 = leap year)
//   year_carry : one-cycle pulse after the Dec 31 -> Jan 1 rollover
module cal_ctrl
  import cal_pkg::*;
#(
  parameter bit          LEAP_EN = 1'b1,
  parameter int unsigned W       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              day_tick,
  input  logic              timeset,
  input  logic              dateadv,
  input  logic              monthadv,
  output logic [W-1:0]      date_out,
  output logic [W-1:0]      month_out,
  output logic [LEAP_W-1:0] leap_phase,
  output logic              year_carry
);

  cal_state_t          r_state;
  cal_state_t          w_state_nxt;
  logic [DATE_W-1:0]   r_date;
  logic [DATE_W-1:0]   w_date_nxt;
  logic [MONTH_W-1:0]  r_month;
  logic [MONTH_W-1:0]  w_month_nxt;
  logic [LEAP_W-1:0]   r_leap;
  logic [LEAP_W-1:0]   w_leap_nxt;
  logic                r_carry;
  logic                w_carry_nxt;

  logic                w_is_leap;
  logic [MONTH_W-1:0]  w_month_inc;
  logic [MONTH_W-1:0]  w_set_month;
  logic [DATE_W-1:0]   w_last_cur;
  logic [DATE_W-1:0]   w_last_set;

  assign w_is_leap   = LEAP_EN && (r_leap == '0);
  assign w_month_inc = (r_month == MONTH_W'(DEC)) ? MONTH_W'(1) : MONTH_W'(r_month + MONTH_W'(1));
  // Month after the set-mode month step; the date is judged against this month.
  assign w_set_month = monthadv ? w_month_inc : r_month;

  cal_month_len u_len_cur (
    .month (r_month),
    .leap  (w_is_leap),
    .last  (w_last_cur)
  );

  cal_month_len u_len_set (
    .month (w_set_month),
    .leap  (w_is_leap),
    .last  (w_last_set)
  );

  // State and calendar registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_date  <= DATE_W'(1);
      r_month <= MONTH_W'(1);
      r_leap  <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_date  <= w_date_nxt;
      r_month <= w_month_nxt;
      r_leap  <= w_leap_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  // Mode transitions and next calendar values; the mode entered at this edge
  // selects the action, so timeset takes effect without a cycle of lag.
  always_comb begin
    w_state_nxt = r_state;
    w_date_nxt  = r_date;
    w_month_nxt = r_month;
    w_leap_nxt  = r_leap;
    w_carry_nxt = 1'b0;

    case (r_state)
      RUN:     if (timeset)  w_state_nxt = SET;
      SET:     if (!timeset) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase

    if (w_state_nxt == SET) begin
      // Buttons wrap locally: no carry into month or leap phase.
      w_month_nxt = w_set_month;
      if (dateadv) begin
        w_date_nxt = (r_date >= w_last_set) ? DATE_W'(1) : DATE_W'(r_date + DATE_W'(1));
      end else if (r_date > w_last_set) begin
        w_date_nxt = w_last_set;
      end
    end else if (day_tick) begin
      if (r_date < w_last_cur) begin
        w_date_nxt = DATE_W'(r_date + DATE_W'(1));
      end else begin
        w_date_nxt = DATE_W'(1);
        if (r_month == MONTH_W'(DEC)) begin
          w_month_nxt = MONTH_W'(1);
          w_leap_nxt  = LEAP_W'(r_leap + LEAP_W'(1));
          w_carry_nxt = 1'b1;
        end else begin
          w_month_nxt = w_month_inc;
        end
      end
    end
  end

  assign date_out   = W'(r_date);
  assign month_out  = W'(r_month);
  assign leap_phase = r_leap;
  assign year_carry = r_carry;

endmodule

// File: tb/tb_cal_ctrl.sv
// Directed bench for cal_ctrl: a LEAP_EN=1 instance plus a LEAP_EN=0 instance
// sharing the same stimulus; a small model only steers button navigation.
module tb_cal_ctrl;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         day_tick;
  logic         timeset;
  logic         dateadv;
  logic         monthadv;
  logic [W-1:0] date_out, month_out;
  logic [1:0]   leap_phase;
  logic         year_carry;
  logic [W-1:0] date_out_nl, month_out_nl;
  logic [1:0]   leap_phase_nl;
  logic         year_carry_nl;

  int n_checks = 0;
  int n_errors = 0;

  // Navigation model of the LEAP_EN=1 instance.
  int md, mm, mlp;

  always #5 clk = ~clk;

  cal_ctrl #(.LEAP_EN(1'b1), .W(W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .day_tick   (day_tick),
    .timeset    (timeset),
    .dateadv    (dateadv),
    .monthadv   (monthadv),
    .date_out   (date_out),
    .month_out  (month_out),
    .leap_phase (leap_phase),
    .year_carry (year_carry)
  );

  cal_ctrl #(.LEAP_EN(1'b0), .W(W)) u_dut_noleap (
    .clk        (clk),
    .rst        (rst),
    .day_tick   (day_tick),
    .timeset    (timeset),
    .dateadv    (dateadv),
    .monthadv   (monthadv),
    .date_out   (date_out_nl),
    .month_out  (month_out_nl),
    .leap_phase (leap_phase_nl),
    .year_carry (year_carry_nl)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lastf(input int m, input int lp);
    if (m == 2) return (lp == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Advance one clock; outputs are sampled 1 ns after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    md = 1; mm = 1; mlp = 0;
  endtask

  // Step to month m, date d in set mode; set mode stays asserted on return.
  task automatic goto_date(input int m, input int d);
    timeset = 1'b1;
    while (mm != m) begin
      monthadv = 1'b1;
      cyc();
      mm = (mm == 12) ? 1 : mm + 1;
      if (md > lastf(mm, mlp)) md = lastf(mm, mlp);
    end
    monthadv = 1'b0;
    while (md != d) begin
      dateadv = 1'b1;
      cyc();
      md = (md >= lastf(mm, mlp)) ? 1 : md + 1;
    end
    dateadv = 1'b0;
  endtask

  task automatic tick();
    timeset  = 1'b0;
    day_tick = 1'b1;
    cyc();
    day_tick = 1'b0;
    if (md < lastf(mm, mlp)) md++;
    else begin
      md = 1;
      if (mm == 12) begin mm = 1; mlp = (mlp + 1) % 4; end
      else mm++;
    end
  endtask

  task automatic check_dm(input string tag, input int m, input int d);
    check({tag, " month"}, int'(month_out), m);
    check({tag, " date"},  int'(date_out),  d);
  endtask

  initial begin
    rst = 1'b0; day_tick = 1'b0; timeset = 1'b0; dateadv = 1'b0; monthadv = 1'b0;
    md = 1; mm = 1; mlp = 0;
    #12;
    check_dm("reset", 1, 1);
    check("reset leap", int'(leap_phase), 0);
    check("reset carry", int'(year_carry), 0);
    check("reset nl date", int'(date_out_nl), 1);
    rst = 1'b1;
    cyc();
    check_dm("post-release", 1, 1);

    // Run-mode date and month steps.
    goto_date(1, 15);
    timeset = 1'b0;
    cyc();
    cyc();
    check_dm("jan15 idle", 1, 15);
    goto_date(1, 31);
    tick();
    check_dm("jan31 tick", 2, 1);
    goto_date(4, 30);
    tick();
    check_dm("apr30 tick", 5, 1);

    // February with and without leap support.
    do_reset();
    goto_date(2, 28);
    tick();
    check_dm("leap feb28", 2, 29);
    check("noleap feb28 month", int'(month_out_nl), 3);
    check("noleap feb28 date", int'(date_out_nl), 1);
    tick();
    check_dm("leap feb29", 3, 1);

    // First rollover moves leap phase to 1; February is then 28 days.
    goto_date(12, 31);
    tick();
    check_dm("yr1", 1, 1);
    check("yr1 leap", int'(leap_phase), 1);
    check("yr1 carry", int'(year_carry), 1);
    cyc();
    check("yr1 carry drop", int'(year_carry), 0);
    goto_date(2, 28);
    tick();
    check_dm("lp1 feb28", 3, 1);
    goto_date(12, 31);
    tick();
    check("yr2 leap", int'(leap_phase), 2);
    goto_date(12, 31);
    tick();
    check("yr3 leap", int'(leap_phase), 3);

    // Phase 3 wraps to 0 with a single-cycle carry.
    goto_date(12, 31);
    tick();
    check_dm("yr4", 1, 1);
    check("yr4 leap wrap", int'(leap_phase), 0);
    check("yr4 carry", int'(year_carry), 1);
    cyc();
    check("yr4 carry drop", int'(year_carry), 0);
    check_dm("yr4 hold", 1, 1);

    // Asynchronous reset mid-count.
    goto_date(7, 15);
    timeset = 1'b0;
    cyc();
    check_dm("jul15", 7, 15);
    #3;
    rst = 1'b0;
    #1;
    check_dm("async reset", 1, 1);
    check("async reset leap", int'(leap_phase), 0);
    check("async reset carry", int'(year_carry), 0);
    rst = 1'b1;
    md = 1; mm = 1; mlp = 0;
    cyc();
    check_dm("async release", 1, 1);

    // Set-mode month step clamps the date.
    goto_date(3, 31);
    monthadv = 1'b1;
    cyc();
    monthadv = 1'b0;
    mm = 4; md = 30;
    check_dm("clamp mar31", 4, 30);
    goto_date(4, 29);
    dateadv = 1'b1;
    cyc();
    check_dm("dateadv 1", 4, 30);
    cyc();
    check_dm("dateadv 2", 4, 1);
    cyc();
    check_dm("dateadv 3", 4, 2);
    dateadv = 1'b0;
    md = 2;

    // day_tick is dropped while in set mode.
    goto_date(12, 31);
    day_tick = 1'b1;
    cyc();
    day_tick = 1'b0;
    check_dm("set tick drop", 12, 31);
    check("set tick carry", int'(year_carry), 0);
    timeset = 1'b0;
    cyc();
    check_dm("exit set", 12, 31);
    check("exit set carry", int'(year_carry), 0);
    tick();
    check_dm("run after set", 1, 1);
    check("run after set carry", int'(year_carry), 1);

    // Both buttons: month steps first, date evaluated against February.
    goto_date(1, 31);
    monthadv = 1'b1;
    dateadv  = 1'b1;
    cyc();
    monthadv = 1'b0;
    dateadv  = 1'b0;
    check_dm("both buttons", 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
